ram_2h_arb: RTL and testbench
=============================

RAM_2H_ARB -- requirements
Module: ram_2h_arb

Interface
REQ-001 SHALL have parameter Depth, default 128, giving the RAM size in 32-bit words.
REQ-002 SHALL have parameter BaseAddr, default 32'h0000_0000, giving the byte address of RAM word 0.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock, rising-edge active.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have host A ports a_req_i (in, 1), a_we_i (in, 1), a_be_i (in, 4), a_addr_i (in, 32) and a_wdata_i (in, 32): the instruction-side request.
REQ-006 SHALL have host A ports a_gnt_o (out, 1), a_rvalid_o (out, 1), a_rdata_o (out, 32) and a_err_o (out, 1): the instruction-side grant and response.
REQ-007 SHALL have host B ports b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i, b_gnt_o, b_rvalid_o, b_rdata_o and b_err_o: the data side, with the same directions and widths as host A.
REQ-008 SHALL have RAM ports ram_req_o (out, 1), ram_we_o (out, 1), ram_be_o (out, 4), ram_addr_o (out, 32) and ram_wdata_o (out, 32): the request to the single-port RAM.
REQ-009 SHALL have RAM ports ram_rvalid_i (in, 1) and ram_rdata_i (in, 32): the response from the RAM, which has a fixed 1-cycle latency.

Function
REQ-010 SHALL grant at most one host per cycle, and SHALL drive each grant combinationally in the same cycle as its request.
REQ-011 SHALL grant the requester immediately, with zero wait cycles, when only one host requests.
REQ-012 SHALL forward the granted host's we, be, addr and wdata unchanged on ram_*_o in the grant cycle.
REQ-013 SHALL drive ram_req_o = 1 only when the granted address is in range.
REQ-014 SHALL treat an address as in range when BaseAddr <= addr < BaseAddr + 4*Depth, using 33-bit unsigned arithmetic so the bound cannot wrap.
REQ-015 SHALL still grant an out-of-range request, SHALL keep ram_req_o = 0 for it, and SHALL return rvalid = 1, err = 1 and rdata = 0 to that host in the next cycle.
REQ-016 SHALL register a response record on every grant: owner (A/B), pending = 1 and oor flag.
REQ-017 SHALL clear pending in any cycle with no grant.
REQ-018 SHALL assert rvalid_o for the owner host exactly one cycle after its grant, for both reads and writes.
REQ-019 SHALL route ram_rdata_i to the owner host's rdata_o with err = 0.
REQ-020 SHALL hold the non-owner host's rvalid_o = 0, err_o = 0 and rdata_o = 0.
REQ-021 SHALL ignore ram_rvalid_i when pending = 0 or oor = 1 (no output change), and SHALL raise the sticky internal flag spurious_q in that case.
REQ-022 SHALL accept a new grant in the same cycle that a previous response is delivered, giving a throughput of 1 request per cycle.
REQ-023 SHALL hold all ram_*_o outputs at 0 when there is no grant.

Reset
REQ-024 SHALL, while rst_ni = 0, hold ram_req_o, all gnt_o, all rvalid_o and all err_o at 0, and all rdata_o at 32'h0.
REQ-025 SHALL reset owner to B, pending to 0, oor to 0 and spurious_q to 0.
REQ-026 SHALL discard a request granted in the cycle before reset asserts: no response is delivered after reset.
REQ-027 SHALL permit grants from the first rising edge after rst_ni deasserts.

Configuration
REQ-028 SHALL implement round-robin arbitration when macro RAM_ARB_ROUND_ROBIN_EN is defined: under contention the host not granted last wins, and the last-granted register updates on every grant and resets to B, so A wins the first contention.
REQ-029 SHALL implement fixed priority when RAM_ARB_ROUND_ROBIN_EN is undefined: B always wins contention, and the last-granted register is absent.

Verification
REQ-030 SHALL pass this scenario: A reads 0x10 alone, with mem[4] = 0xDEADBEEF -> a_gnt_o = 1 in cycle 0, then a_rvalid_o = 1 and a_rdata_o = 0xDEADBEEF in cycle 1, with b_rvalid_o = 0.
REQ-031 SHALL pass this scenario: A and B request together for 3 cycles with the macro defined -> grants A, B, A, each with rvalid one cycle later; with the macro undefined -> grants B, B, B.
REQ-032 SHALL pass this scenario: B writes 0xCAFEF00D to 0x20 with be = 4'b0011, then A reads 0x20 -> b_rvalid_o = 1 and b_err_o = 0 after the write, then a_rdata_o[15:0] = 0xF00D.
REQ-033 SHALL pass this scenario: B reads 0x200 with Depth = 128 -> b_gnt_o = 1 and ram_req_o = 0, then next cycle b_rvalid_o = 1, b_err_o = 1 and b_rdata_o = 0.
REQ-034 SHALL pass this scenario: rst_ni pulses low for one cycle immediately after an A grant -> a_rvalid_o stays 0 and arbitration restarts with A preferred.

Source files
------------

// File: rtl/ram_2h_arb.sv
// ram_2h_arb -- two-host arbiter in front of a single-port, 1-cycle-latency RAM.
//
// Host A (instruction side) and host B (data side) each present a request.
// Grants are combinational, and at most one host is granted per cycle.
// The granted request is forwarded unchanged to the RAM. Its response is
// returned to the owning host exactly one cycle later.
//
// An address outside [BaseAddr, BaseAddr + 4*Depth) is still granted, but it
// never reaches the RAM. Instead, the host gets err = 1 with rdata = 0.
//
// Parameters:
//   Depth    - RAM size in 32-bit words
//   BaseAddr - byte address of RAM word 0
//
// Configuration macro:
//   RAM_ARB_ROUND_ROBIN_EN - defined:   round-robin under contention
//                                       (A wins first after reset)
//                            undefined: fixed priority, B always wins
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   a_req_i/we_i/be_i/addr_i/wdata_i     host A request
//   a_gnt_o/rvalid_o/rdata_o/err_o       host A grant and response
//   b_*                                  host B, same shape as host A
//   ram_req_o/we_o/be_o/addr_o/wdata_o   request to the RAM
//   ram_rvalid_i, ram_rdata_i            RAM response (fixed 1-cycle latency)
module ram_2h_arb #(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        a_req_i,
    input  logic        a_we_i,
    input  logic [3:0]  a_be_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_gnt_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,
    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [3:0]  b_be_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_gnt_o,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        b_err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic gnt_a, gnt_b, granted;

    // Grants are gated by rst_ni, so nothing is granted while reset is held.
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_b_q;  // 1: B was granted last

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_ni) begin
            if (a_req_i && b_req_i) begin
                gnt_a = last_b_q;
                gnt_b = ~last_b_q;
            end else begin
                gnt_a = a_req_i;
                gnt_b = b_req_i;
            end
        end
    end

    // Resets to B, so A wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      last_b_q <= 1'b1;
        else if (granted) last_b_q <= gnt_b;
    end
`else
    always_comb begin
        gnt_b = rst_ni & b_req_i;
        gnt_a = rst_ni & a_req_i & ~b_req_i;
    end
`endif

    assign granted = gnt_a | gnt_b;
    assign a_gnt_o = gnt_a;
    assign b_gnt_o = gnt_b;

    req_t sel;
    assign sel = gnt_b ? '{b_we_i, b_be_i, b_addr_i, b_wdata_i}
                       : '{a_we_i, a_be_i, a_addr_i, a_wdata_i};

    // Compare in 33 bits so that BaseAddr + 4*Depth cannot wrap around.
    logic [32:0] addr_ext, lo_ext, hi_ext;
    logic        in_range;
    assign addr_ext = {1'b0, sel.addr};
    assign lo_ext   = {1'b0, BaseAddr};
    assign hi_ext   = lo_ext + (33'(Depth) << 2);
    assign in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);

    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        if (granted) begin
            ram_req_o   = in_range;
            ram_we_o    = sel.we;
            ram_be_o    = sel.be;
            ram_addr_o  = sel.addr;
            ram_wdata_o = sel.wdata;
        end
    end

    // Response record: owner (1 = B), pending, out-of-range flag.
    logic owner_b_q, pending_q, oor_q, spurious_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_b_q <= 1'b1;
            pending_q <= 1'b0;
            oor_q     <= 1'b0;
        end else if (granted) begin
            owner_b_q <= gnt_b;
            pending_q <= 1'b1;
            oor_q     <= ~in_range;
        end else begin
            pending_q <= 1'b0;
        end
    end

    // Sticky flag for a RAM response that no in-range request asked for.
    // Such a response is never forwarded to either host.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                 spurious_q <= 1'b0;
        else if (ram_rvalid_i && (!pending_q || oor_q)) spurious_q <= 1'b1;
    end

    // rvalid depends on pending_q rather than ram_rvalid_i, so writes get
    // their one-cycle acknowledge too. An async reset clears pending_q, so
    // a grant made just before reset is never answered.
    logic        rsp_err;
    logic [31:0] rsp_data;
    assign rsp_err  = oor_q;
    assign rsp_data = oor_q ? 32'h0 : ram_rdata_i;

    always_comb begin
        a_rvalid_o = 1'b0;
        a_err_o    = 1'b0;
        a_rdata_o  = 32'h0;
        b_rvalid_o = 1'b0;
        b_err_o    = 1'b0;
        b_rdata_o  = 32'h0;
        if (pending_q) begin
            if (owner_b_q) begin
                b_rvalid_o = 1'b1;
                b_err_o    = rsp_err;
                b_rdata_o  = rsp_data;
            end else begin
                a_rvalid_o = 1'b1;
                a_err_o    = rsp_err;
                a_rdata_o  = rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_2h_arb.sv
module tb_ram_2h_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_req, ram_we, ram_rvalid;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_2h_arb #(.Depth(128), .BaseAddr(32'h0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
        .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
    );

    // Behavioural single-port RAM, 128 words, 1-cycle latency.
    logic [31:0] mem [128];
    always @(posedge clk) begin
        ram_rvalid <= ram_req;
        ram_rdata  <= 32'h0;
        if (ram_req) begin
            if (ram_we) begin
                for (int k = 0; k < 4; k++)
                    if (ram_be[k]) mem[ram_addr[8:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[8:2]];
            end
        end
    end

    typedef struct {
        bit          is_b;
        bit          err;
        logic [31:0] data;
        logic [31:0] mask;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is due on every negedge while the queue is non-empty.
    always @(negedge clk) begin
        rsp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_a_rvalid", {31'h0, a_rvalid}, {31'h0, ~e.is_b});
            chk("rsp_b_rvalid", {31'h0, b_rvalid}, {31'h0, e.is_b});
            chk("rsp_err", {31'h0, e.is_b ? b_err : a_err}, {31'h0, e.err});
            chk("rsp_data", (e.is_b ? b_rdata : a_rdata) & e.mask, e.data & e.mask);
            chk("rsp_other_zero", {e.is_b ? a_rdata : b_rdata}, 32'h0);
            chk("rsp_other_err", {31'h0, e.is_b ? a_err : b_err}, 32'h0);
        end else if (a_rvalid || b_rvalid) begin
            chk("unexpected_rvalid", {30'h0, b_rvalid, a_rvalid}, 32'h0);
        end
    end

    // One cycle of stimulus. eg = {b_gnt, a_gnt} expected.
    task automatic step(input bit ar, input logic [31:0] aa,
                        input bit br, input bit bw, input logic [3:0] bbe,
                        input logic [31:0] ba, input logic [31:0] bwd,
                        input bit [1:0] eg, input bit eram, input bit push,
                        input bit eerr, input logic [31:0] edata, input logic [31:0] emask);
        rsp_t r;
        @(negedge clk);
        a_req = ar; a_we = 1'b0; a_be = 4'hF; a_addr = aa; a_wdata = 32'h0;
        b_req = br; b_we = bw; b_be = bbe; b_addr = ba; b_wdata = bwd;
        #1;
        chk("gnt", {30'h0, b_gnt, a_gnt}, {30'h0, eg});
        chk("ram_req", {31'h0, ram_req}, {31'h0, eram});
        if (eg != 2'b00) begin
            chk("ram_addr", ram_addr, eg[1] ? ba : aa);
            if (eg[1]) chk("ram_wdata", ram_wdata, bwd);
            if (push) begin
                r.is_b = eg[1]; r.err = eerr; r.data = edata; r.mask = emask;
                exp_q.push_back(r);
            end
        end else begin
            chk("idle_ram", {ram_we, ram_be, 27'h0} | ram_addr | ram_wdata, 32'h0);
        end
    endtask

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[4]   = 32'hDEAD_BEEF;
        mem[5]   = 32'h1111_1111;
        mem[127] = 32'h7F7F_7F7F;
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;

        // Held in reset with both hosts requesting: everything quiet.
        repeat (2) @(negedge clk);
        a_req = 1; b_req = 1; a_addr = 32'h10; b_addr = 32'h14;
        #1;
        chk("rst_gnt", {30'h0, b_gnt, a_gnt}, 32'h0);
        chk("rst_ram_req", {31'h0, ram_req}, 32'h0);
        chk("rst_rsp", {30'h0, b_rvalid, a_rvalid} | {30'h0, b_err, a_err} | a_rdata | b_rdata, 32'h0);
        a_req = 0; b_req = 0;
        #2 rst_n = 1'b1;

        // Contention for three cycles.
`ifdef RAM_ARB_ROUND_ROBIN_EN
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b01, 1, 1, 0, 32'hDEAD_BEEF, ALL);
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b10, 1, 1, 0, 32'h1111_1111, ALL);
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b01, 1, 1, 0, 32'hDEAD_BEEF, ALL);
`else
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b10, 1, 1, 0, 32'h1111_1111, ALL);
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b10, 1, 1, 0, 32'h1111_1111, ALL);
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b10, 1, 1, 0, 32'h1111_1111, ALL);
`endif
        // Idle cycle: RAM port all zero.
        step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        // A reads 0x10 alone.
        step(1, 32'h10, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 32'hDEAD_BEEF, ALL);
        // B writes 0xCAFEF00D to 0x20 (low half only), then A reads it back.
        step(0, 0, 1, 1, 4'b0011, 32'h20, 32'hCAFE_F00D, 2'b10, 1, 1, 0, 0, 0);
        step(1, 32'h20, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 32'h0000_F00D, 32'h0000_FFFF);
        // Last in-range word, then first out-of-range, then far out of range.
        step(0, 0, 1, 0, 4'hF, 32'h1FC, 0, 2'b10, 1, 1, 0, 32'h7F7F_7F7F, ALL);
        step(0, 0, 1, 0, 4'hF, 32'h200, 0, 2'b10, 0, 1, 1, 32'h0, ALL);
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 2'b01, 0, 1, 1, 32'h0, ALL);
        // A back in range directly after an error response.
        step(1, 32'h14, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 32'h1111_1111, ALL);

        // Reset pulse right after an A grant: no response may appear.
        step(1, 32'h10, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstp_gnt", {30'h0, b_gnt, a_gnt}, 32'h0);
        chk("rstp_rvalid", {30'h0, b_rvalid, a_rvalid}, 32'h0);
        chk("rstp_ram_req", {31'h0, ram_req}, 32'h0);
        a_req = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b01, 1, 1, 0, 32'hDEAD_BEEF, ALL);
`else
        step(1, 32'h10, 1, 0, 4'hF, 32'h14, 0, 2'b10, 1, 1, 0, 32'h1111_1111, ALL);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
